// File: rtl/fp_mul_sched.sv
// Round-robin issue of two requesters onto one shared pipelined FP multiplier, results routed back by tag.
// Accept edge to result edge is LATENCY+1, one op per cycle; hold only blocks issue, results have no backpressure.
module fp_mul_sched #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  input  logic             hold,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_in_valid,
  input  logic [WIDTH-1:0] mul_res,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid0,
  output logic             res_valid1,
  output logic [4:0]       inflight,
  output logic             busy
);

  logic             rr_q, rr_d;
  logic [LATENCY:0] tag_vld_q, tag_vld_d;
  logic [LATENCY:0] tag_id_q, tag_id_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             mul_vld_q, mul_vld_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;
  logic [4:0]       inflight_q, inflight_d;
  logic             accept;
  logic             out_vld;
  logic             out_id;

  // rr_q names the requester that wins when both ask in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0 && (!req1 || !rr_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept  = gnt0 | gnt1;
  assign out_vld = tag_vld_q[LATENCY];
  assign out_id  = tag_id_q[LATENCY];

  always_comb begin
    rr_d       = rr_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_vld_d  = accept;
    tag_vld_d  = {tag_vld_q[LATENCY-1:0], accept};
    tag_id_d   = {tag_id_q[LATENCY-1:0], gnt1};
    res_data_d = res_data_q;
    rv0_d      = out_vld & ~out_id;
    rv1_d      = out_vld & out_id;
    inflight_d = inflight_q + 5'(accept) - 5'(out_vld);
    if (accept) begin
      rr_d    = ~gnt1;
      mul_a_d = gnt1 ? a1 : a0;
      mul_b_d = gnt1 ? b1 : b0;
    end
    // The last tag stage lines up with the multiplier's output register.
    if (out_vld) begin
      res_data_d = mul_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_vld_q  <= 1'b0;
      res_data_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      rr_q       <= rr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_vld_q  <= mul_vld_d;
      res_data_q <= res_data_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      inflight_q <= inflight_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_in_valid = mul_vld_q;
  assign res_data     = res_data_q;
  assign res_valid0   = rv0_q;
  assign res_valid1   = rv1_q;
  assign inflight     = inflight_q;
  assign busy         = |inflight_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched: behavioural multiplier + issue/delivery scoreboard, directed literals, random traffic.
module tb_fp_mul_sched;
  localparam int L = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, hold = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, mul_in_valid, res_valid0, res_valid1, busy;
  logic [W-1:0] mul_a, mul_b, mul_res, res_data;
  logic [4:0]   inflight;

  fp_mul_sched #(.LATENCY(L), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .hold(hold), .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
    .mul_res(mul_res), .res_data(res_data), .res_valid0(res_valid0), .res_valid1(res_valid1),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single-precision multiply, round to nearest even, normals and signed zero only.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] ma, mb, p;
    logic [23:0] m;
    logic [24:0] r;
    logic        g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'b0};
    ma = {24'b0, 1'b1, a[22:0]};
    mb = {24'b0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) begin
      r = {1'b0, m} + 25'd1;
      if (r[24]) begin
        m = 24'h800000; e = e + 1;
      end else begin
        m = r[23:0];
      end
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
    return v;
  endfunction

  // Free-running multiplier: operands sampled at edge k appear on mul_res before edge k+L.
  logic [W-1:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= fpmul(mul_a, mul_b);
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_res = mpipe[L-1];

  // Reference model: arbitration rule, queue of issued ops with their due edge.
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] d;
  } exp_t;
  exp_t        q[$];
  int          edge_n = 0;
  bit          m_ptr = 1'b0;
  bit          acc0_m = 1'b0, acc1_m = 1'b0;
  bit          m_miv = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_resd = '0;

  function automatic void model_gnt(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!hold) begin
      if (req0 && req1) begin
        g0 = !m_ptr; g1 = m_ptr;
      end else begin
        g0 = req0; g1 = req1;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit   g0, g1;
    exp_t e;
    edge_n++;
    if (rst) begin
      q.delete();
      m_ptr = 1'b0; m_miv = 1'b0; acc0_m = 1'b0; acc1_m = 1'b0;
      m_a = '0; m_b = '0; m_resd = '0;
    end else begin
      model_gnt(g0, g1);
      acc0_m = g0;
      acc1_m = g1;
      m_miv  = g0 | g1;
      if (g0 || g1) begin
        m_a   = g1 ? a1 : a0;
        m_b   = g1 ? b1 : b0;
        m_ptr = !g1;
        e.due = edge_n + L + 1;
        e.id  = g1;
        e.d   = fpmul(m_a, m_b);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    bit ev, eid, g0, g1;
    if (edge_n > 0) begin
      ev  = 1'b0;
      eid = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        ev = 1'b1; eid = q[0].id; m_resd = q[0].d;
        void'(q.pop_front());
      end
      chk("res_valid0", {31'b0, res_valid0}, {31'b0, ev && !eid});
      chk("res_valid1", {31'b0, res_valid1}, {31'b0, ev && eid});
      chk("res_data", res_data, m_resd);
      chk("inflight", {27'b0, inflight}, 32'(q.size()));
      chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
      chk("mul_in_valid", {31'b0, mul_in_valid}, {31'b0, m_miv});
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      if (!rst) begin
        model_gnt(g0, g1);
        chk("gnt0", {31'b0, gnt0}, {31'b0, g0});
        chk("gnt1", {31'b0, gnt1}, {31'b0, g1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          pulses, pos, ng, maxf, first, last, n, cnt0, gcnt;
    logic [31:0] data;
    int          gid [4];
    int          rid [4];
    logic [31:0] rdat [4];
    logic [31:0] c0a [2], c0b [2], c1a [2], c1b [2];
    int          i0, i1;
    bit          pend0, pend1;

    // Single op: 2.0 * 3.0
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_inflight", {27'b0, inflight}, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    step();
    req0 = 1'b1; a0 = 32'h40000000; b0 = 32'h40400000;
    @(negedge clk);
    chk("single_gnt0", {31'b0, gnt0}, 32'd1);
    step();
    req0 = 1'b0;
    pulses = 0; pos = -1; data = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid0) begin
        pulses++;
        if (pos < 0) pos = i;
        data = res_data;
      end
    end
    chk("single_pulses", 32'(pulses), 32'd1);
    chk("single_pos", 32'(pos), 32'd5);
    chk("single_data", data, 32'h40C00000);
    chk("single_inflight_end", {27'b0, inflight}, 32'd0);

    // Contention after reset: grants alternate starting with requester 0
    step(); rst = 1'b1; step(); rst = 1'b0;
    c0a[0] = 32'h3FC00000; c0b[0] = 32'h40000000;
    c0a[1] = 32'h40000000; c0b[1] = 32'h40000000;
    c1a[0] = 32'h40400000; c1b[0] = 32'h40000000;
    c1a[1] = 32'h3F800000; c1b[1] = 32'h3F800000;
    i0 = 0; i1 = 0;
    req0 = 1'b1; a0 = c0a[0]; b0 = c0b[0];
    req1 = 1'b1; a1 = c1a[0]; b1 = c1b[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gid[i] = gnt1 ? 1 : (gnt0 ? 0 : 9);
      step();
      if (gid[i] == 0) begin
        i0++;
        if (i0 < 2) begin a0 = c0a[i0]; b0 = c0b[i0]; end
      end else if (gid[i] == 1) begin
        i1++;
        if (i1 < 2) begin a1 = c1a[i1]; b1 = c1b[i1]; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_g0", 32'(gid[0]), 32'd0);
    chk("cont_g1", 32'(gid[1]), 32'd1);
    chk("cont_g2", 32'(gid[2]), 32'd0);
    chk("cont_g3", 32'(gid[3]), 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((res_valid0 || res_valid1) && n < 4) begin
        rid[n] = res_valid1 ? 1 : 0;
        rdat[n] = res_data;
        n++;
      end
    end
    chk("cont_nres", 32'(n), 32'd4);
    if (n == 4) begin
      chk("cont_r0_id", 32'(rid[0]), 32'd0); chk("cont_r0_dat", rdat[0], 32'h40400000);
      chk("cont_r1_id", 32'(rid[1]), 32'd1); chk("cont_r1_dat", rdat[1], 32'h40C00000);
      chk("cont_r2_id", 32'(rid[2]), 32'd0); chk("cont_r2_dat", rdat[2], 32'h40800000);
      chk("cont_r3_id", 32'(rid[3]), 32'd1); chk("cont_r3_dat", rdat[3], 32'h3F800000);
    end

    // Back-to-back on requester 1
    step();
    req1 = 1'b1; a1 = rnd_fp(); b1 = rnd_fp();
    ng = 0; maxf = 0; pulses = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt1) ng++;
      if (res_valid1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
      if (int'(inflight) > maxf) maxf = int'(inflight);
      step();
      if (i == 7) req1 = 1'b0;
      else begin a1 = rnd_fp(); b1 = rnd_fp(); end
    end
    chk("b2b_grants", 32'(ng), 32'd8);
    chk("b2b_max_inflight", 32'(maxf), 32'd5);
    chk("b2b_pulses", 32'(pulses), 32'd8);
    chk("b2b_span", 32'(last - first), 32'd7);

    // hold blocks grants, in-flight ops still drain
    hold = 1'b1; req0 = 1'b1; a0 = rnd_fp(); b0 = rnd_fp();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_gnt0", {31'b0, gnt0}, 32'd0);
      chk("hold_miv", {31'b0, mul_in_valid}, 32'd0);
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_gnt0", {31'b0, gnt0}, 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      a0 = rnd_fp(); b0 = rnd_fp();
      @(negedge clk);
      step();
    end
    hold = 1'b1; a0 = rnd_fp(); b0 = rnd_fp();
    @(negedge clk);
    chk("hold_inflight3", {27'b0, inflight}, 32'd3);
    cnt0 = 0; gcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid0) cnt0++;
      if (gnt0) gcnt++;
      step();
    end
    chk("hold_drained", 32'(cnt0), 32'd3);
    chk("hold_no_gnt", 32'(gcnt), 32'd0);
    chk("hold_busy_low", {31'b0, busy}, 32'd0);
    hold = 1'b0;
    @(negedge clk);
    step();
    req0 = 1'b0;

    // Reset with three ops in flight
    step();
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a0 = rnd_fp(); b0 = rnd_fp();
      step();
    end
    req0 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_miv", {31'b0, mul_in_valid}, 32'd0);
    chk("rst_inflight", {27'b0, inflight}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid0 || res_valid1) pulses++;
    end
    chk("rst_no_pulses", 32'(pulses), 32'd0);

    // Pointer back at requester 0; zero and negative-zero pass through
    step();
    req0 = 1'b1; a0 = 32'h00000000; b0 = 32'h3F800000;
    req1 = 1'b1; a1 = 32'h80000000; b1 = 32'h3F800000;
    @(negedge clk);
    chk("rst_ptr_gnt0", {31'b0, gnt0}, 32'd1);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("zero_gnt1", {31'b0, gnt1}, 32'd1);
    step();
    req1 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((res_valid0 || res_valid1) && n < 2) begin
        rid[n] = res_valid1 ? 1 : 0;
        rdat[n] = res_data;
        n++;
      end
    end
    chk("zero_nres", 32'(n), 32'd2);
    if (n == 2) begin
      chk("zero_r0_id", 32'(rid[0]), 32'd0); chk("zero_r0_dat", rdat[0], 32'h00000000);
      chk("zero_r1_id", 32'(rid[1]), 32'd1); chk("zero_r1_dat", rdat[1], 32'h80000000);
    end

    // Random traffic, requests held stable until granted, occasional hold and reset
    step();
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; pend0 = 1'b0; pend1 = 1'b0;
      end
      if (acc0_m) pend0 = 1'b0;
      if (acc1_m) pend1 = 1'b0;
      if (!rst && !pend0 && $urandom_range(0, 9) < 6) begin
        pend0 = 1'b1; a0 = rnd_fp(); b0 = rnd_fp();
      end
      if (!rst && !pend1 && $urandom_range(0, 9) < 6) begin
        pend1 = 1'b1; a1 = rnd_fp(); b1 = rnd_fp();
      end
      req0 = pend0 && !rst;
      req1 = pend1 && !rst;
      hold = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    chk("drain_inflight", {27'b0, inflight}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
